// File: rtl/excess3_serial_decoder_if.sv
// Serial Excess-3 link toward the decoder and its decoded bit/digit/word outputs.
// The source uses the master modport; the decoder uses the slave modport.
interface excess3_serial_decoder_if #(
    parameter int DIGITS = 2
);
    logic                  in_valid;
    logic                  in_bit;
    logic                  out_valid;
    logic                  out_bit;
    logic                  digit_valid;
    logic [3:0]            digit;
    logic                  digit_err;
    logic                  word_valid;
    logic [4*DIGITS-1:0]   word;
    logic                  word_err;

    modport master (
        output in_valid, in_bit,
        input  out_valid, out_bit, digit_valid, digit, digit_err,
        input  word_valid, word, word_err
    );

    modport slave (
        input  in_valid, in_bit,
        output out_valid, out_bit, digit_valid, digit, digit_err,
        output word_valid, word, word_err
    );
endinterface

// File: rtl/excess3_serial_decoder.sv
// Bit-serial Excess-3 to BCD decoder: subtracts 3 with a serial borrow chain, LSB first,
// then assembles the decoded digits into a DIGITS-wide BCD word with error flags.
module excess3_serial_decoder #(
    parameter int DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    excess3_serial_decoder_if.slave       bus
);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    logic [1:0]            r_bitIdx;
    logic                  r_borrow;
    logic [3:0]            r_digitSr;
    logic [IDXW-1:0]       r_digIdx;
    logic [4*DIGITS-1:0]   r_wordStage;
    logic                  r_errAcc;

    logic                  r_outValid;
    logic                  r_outBit;
    logic                  r_digitValid;
    logic [3:0]            r_digit;
    logic                  r_digitErr;
    logic                  r_wordValid;
    logic [4*DIGITS-1:0]   r_word;
    logic                  r_wordErr;

    logic                  w_sub;
    logic                  w_borrowIn;
    logic                  w_diff;
    logic                  w_borrowNext;
    logic [3:0]            w_digitNext;
    logic                  w_digitErr;
    logic [4*DIGITS-1:0]   w_wordNext;

    // The subtrahend 3 is 0011, and bit 0 always starts with no borrow.
    always_comb begin
        w_sub        = (r_bitIdx == 2'd0) || (r_bitIdx == 2'd1);
        w_borrowIn   = (r_bitIdx == 2'd0) ? 1'b0 : r_borrow;
        w_diff       = bus.in_bit ^ w_sub ^ w_borrowIn;
        w_borrowNext = (~bus.in_bit & (w_sub | w_borrowIn)) | (w_sub & w_borrowIn);
        w_digitNext  = r_digitSr;
        w_digitNext[r_bitIdx] = w_diff;
        w_digitErr   = w_borrowNext || (w_digitNext > 4'd9);
        w_wordNext   = r_wordStage;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_digIdx == IDXW'(k)) begin
                w_wordNext[4*k +: 4] = w_digitNext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitIdx     <= '0;
            r_borrow     <= 1'b0;
            r_digitSr    <= '0;
            r_digIdx     <= '0;
            r_wordStage  <= '0;
            r_errAcc     <= 1'b0;
            r_outValid   <= 1'b0;
            r_outBit     <= 1'b0;
            r_digitValid <= 1'b0;
            r_digit      <= '0;
            r_digitErr   <= 1'b0;
            r_wordValid  <= 1'b0;
            r_word       <= '0;
            r_wordErr    <= 1'b0;
        end else begin
            r_outValid   <= 1'b0;
            r_digitValid <= 1'b0;
            r_wordValid  <= 1'b0;
            if (bus.in_valid) begin
                r_outValid <= 1'b1;
                r_outBit   <= w_diff;
                r_bitIdx   <= r_bitIdx + 2'd1;
                r_borrow   <= w_borrowNext;
                r_digitSr  <= w_digitNext;
                if (r_bitIdx == 2'd3) begin
                    r_digitValid <= 1'b1;
                    r_digit      <= w_digitNext;
                    r_digitErr   <= w_digitErr;
                    // The visible word only changes once its last nibble lands.
                    if (r_digIdx == LAST_IDX) begin
                        r_wordValid <= 1'b1;
                        r_word      <= w_wordNext;
                        r_wordErr   <= r_errAcc | w_digitErr;
                        r_errAcc    <= 1'b0;
                        r_digIdx    <= '0;
                        r_wordStage <= '0;
                    end else begin
                        r_errAcc    <= r_errAcc | w_digitErr;
                        r_digIdx    <= r_digIdx + IDXW'(1);
                        r_wordStage <= w_wordNext;
                    end
                end
            end
        end
    end

    assign bus.out_valid   = r_outValid;
    assign bus.out_bit     = r_outBit;
    assign bus.digit_valid = r_digitValid;
    assign bus.digit       = r_digit;
    assign bus.digit_err   = r_digitErr;
    assign bus.word_valid  = r_wordValid;
    assign bus.word        = r_word;
    assign bus.word_err    = r_wordErr;
endmodule

// File: tb/tb_excess3_serial_decoder.sv
// Directed bench for the serial Excess-3 decoder with DIGITS=2: hand-computed digits,
// words, error flags, in_valid gaps and mid-digit reset.
module tb_excess3_serial_decoder;
    localparam int DIGITS = 2;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    excess3_serial_decoder_if #(.DIGITS(DIGITS)) bus ();

    excess3_serial_decoder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic vld, input logic b);
        bus.in_valid = vld;
        bus.in_bit   = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, ".digit_valid"}, 32'(bus.digit_valid), 32'd0);
        checkOutput({tag, ".word_valid"}, 32'(bus.word_valid), 32'd0);
    endtask

    // Sends one 4-bit code LSB first; gapMask[i] inserts an idle cycle before bit i.
    task automatic sendDigit(input string tag, input logic [3:0] code, input logic [3:0] gapMask,
                             input logic [3:0] expDigit, input logic expErr);
        for (int i = 0; i < 4; i++) begin
            if (gapMask[i]) begin
                applyStimulus(1'b0, 1'b0);
                checkIdle($sformatf("%s.gap%0d", tag, i));
            end
            applyStimulus(1'b1, code[i]);
            checkOutput($sformatf("%s.out_valid%0d", tag, i), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("%s.out_bit%0d", tag, i), 32'(bus.out_bit), 32'(expDigit[i]));
            checkOutput($sformatf("%s.digit_valid%0d", tag, i), 32'(bus.digit_valid), (i == 3) ? 32'd1 : 32'd0);
        end
        checkOutput({tag, ".digit"}, 32'(bus.digit), 32'(expDigit));
        checkOutput({tag, ".digit_err"}, 32'(bus.digit_err), 32'(expErr));
    endtask

    task automatic checkWord(input string tag, input logic vld, input logic [7:0] expWord, input logic expErr);
        checkOutput({tag, ".word_valid"}, 32'(bus.word_valid), 32'(vld));
        checkOutput({tag, ".word"}, 32'(bus.word), 32'(expWord));
        checkOutput({tag, ".word_err"}, 32'(bus.word_err), 32'(expErr));
    endtask

    task automatic checkAllZero(input string tag);
        checkIdle(tag);
        checkOutput({tag, ".out_bit"}, 32'(bus.out_bit), 32'd0);
        checkOutput({tag, ".digit"}, 32'(bus.digit), 32'd0);
        checkOutput({tag, ".digit_err"}, 32'(bus.digit_err), 32'd0);
        checkOutput({tag, ".word"}, 32'(bus.word), 32'd0);
        checkOutput({tag, ".word_err"}, 32'(bus.word_err), 32'd0);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        reset = 1'b0;
        checkAllZero("reset");

        // Word 1: 0011 -> 0, 1100 -> 9
        sendDigit("c0011", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        checkWord("w1.d0", 1'b0, 8'h00, 1'b0);
        sendDigit("c1100", 4'b1100, 4'b0000, 4'b1001, 1'b0);
        checkWord("w1", 1'b1, 8'h90, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkIdle("w1.after");
        checkWord("w1.hold", 1'b0, 8'h90, 1'b0);

        // Word 2: invalid 0001 -> E, invalid 1101 -> A
        sendDigit("c0001", 4'b0001, 4'b0000, 4'b1110, 1'b1);
        checkWord("w2.d0", 1'b0, 8'h90, 1'b0);
        sendDigit("c1101", 4'b1101, 4'b0000, 4'b1010, 1'b1);
        checkWord("w2", 1'b1, 8'hAE, 1'b1);

        // Word 3: 0101 -> 2, 0100 -> 1; error accumulator must have cleared
        sendDigit("c0101", 4'b0101, 4'b0000, 4'b0010, 1'b0);
        sendDigit("c0100", 4'b0100, 4'b0000, 4'b0001, 1'b0);
        checkWord("w3", 1'b1, 8'h12, 1'b0);

        // Word 4: 0100 -> 1 then 1011 -> 8, back-to-back with no gaps
        sendDigit("b2b.c0100", 4'b0100, 4'b0000, 4'b0001, 1'b0);
        checkWord("w4.d0", 1'b0, 8'h12, 1'b0);
        sendDigit("b2b.c1011", 4'b1011, 4'b0000, 4'b1000, 1'b0);
        checkWord("w4", 1'b1, 8'h81, 1'b0);

        // Word 5: same stream with in_valid gaps, including between bits 1 and 2
        sendDigit("gap.c0100", 4'b0100, 4'b0101, 4'b0001, 1'b0);
        checkWord("w5.d0", 1'b0, 8'h81, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkIdle("w5.mid");
        checkOutput("w5.hold_digit", 32'(bus.digit), 32'd1);
        sendDigit("gap.c1011", 4'b1011, 4'b1110, 4'b1000, 1'b0);
        checkWord("w5", 1'b1, 8'h81, 1'b0);

        // Reset after two bits of digit 0, with in_valid also high during reset
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1);
        reset = 1'b0;
        checkAllZero("midreset");

        // After reset: 1000 -> 5 as digit 0, then 0011 -> 0 completes the word
        sendDigit("rst.c1000", 4'b1000, 4'b0000, 4'b0101, 1'b0);
        checkWord("w6.d0", 1'b0, 8'h00, 1'b0);
        sendDigit("rst.c0011", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        checkWord("w6", 1'b1, 8'h05, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
